// File: rtl/mem_arb_pkg.sv
// Types shared by the unified-memory arbiter and its starvation guard.
package mem_arb_pkg;

    typedef enum logic {
        ARB_D_PRIO  = 1'b0,
        ARB_I_FORCE = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_I    = 2'd1,
        RESP_D    = 2'd2
    } resp_tag_t;

endpackage

// File: rtl/rv32i_defs.sv
// Memory access-mode encodings shared by the core and every memory-side block.
package rv32i_defs;

    localparam int MEMORY_MODE_WIDTH = 2;

    localparam logic [MEMORY_MODE_WIDTH-1:0] BYTE_MEMORY_MODE = 2'd0;
    localparam logic [MEMORY_MODE_WIDTH-1:0] HALF_MEMORY_MODE = 2'd1;
    localparam logic [MEMORY_MODE_WIDTH-1:0] WORD_MEMORY_MODE = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory command bus of the unified-memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MODE_WIDTH = rv32i_defs::MEMORY_MODE_WIDTH
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [MODE_WIDTH-1:0] d_mode;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [MODE_WIDTH-1:0] mem_mode;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requesters plus memory: drives requests and read data.
    modport master (
        output i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_read, mem_write, mem_mode, mem_addr, mem_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_read, mem_write, mem_mode, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation guard: counts denied fetch cycles and forces one fetch grant
// through after MAX_WAIT of them.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic i_gnt_i,
    output logic force_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    arb_state_t    state_q;
    logic [CW-1:0] wait_cnt_q;
    logic          force_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_D_PRIO;
            wait_cnt_q <= '0;
            force_q    <= 1'b0;
        end else begin
            if (!i_req_i || i_gnt_i)
                wait_cnt_q <= '0;
            else if (wait_cnt_q != WAIT_MAX)
                wait_cnt_q <= wait_cnt_q + 1'b1;

            case (state_q)
                ARB_D_PRIO: begin
                    if (wait_cnt_q == WAIT_MAX) begin
                        state_q <= ARB_I_FORCE;
                        force_q <= 1'b1;
                    end
                end
                ARB_I_FORCE: begin
                    // Exactly one cycle of fetch priority per expiry.
                    state_q <= ARB_D_PRIO;
                    force_q <= 1'b0;
                end
                default: begin
                    state_q <= ARB_D_PRIO;
                    force_q <= 1'b0;
                end
            endcase
        end
    end

    assign force_o = force_q;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import rv32i_defs::*;
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MODE_WIDTH = MEMORY_MODE_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [MODE_WIDTH-1:0] MODE_WORD = MODE_WIDTH'(WORD_MEMORY_MODE);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mem_arbiter: MAX_WAIT must be >= 1");
    end

    logic force_i;
    logic i_gnt, d_gnt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_req_i (bus.i_req),
        .i_gnt_i (i_gnt),
        .force_o (force_i)
    );
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (force_i) begin
                if (bus.i_req)      i_gnt = 1'b1;
                else if (bus.d_req) d_gnt = 1'b1;
            end else begin
                if (bus.d_req)      d_gnt = 1'b1;
                else if (bus.i_req) i_gnt = 1'b1;
            end
        end
    end

    logic                  mem_read_d,  mem_read_q;
    logic                  mem_write_d, mem_write_q;
    logic [MODE_WIDTH-1:0] mem_mode_d,  mem_mode_q;
    logic [ADDR_WIDTH-1:0] mem_addr_d,  mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_d, mem_wdata_q;
    resp_tag_t             cmd_tag_d,   cmd_tag_q;
    resp_tag_t             resp_d,      resp_q;

    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_mode_d  = mem_mode_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cmd_tag_d   = cmd_tag_q;
        if (d_gnt) begin
            mem_read_d  = !bus.d_we;
            mem_write_d = bus.d_we;
            mem_mode_d  = bus.d_mode;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            cmd_tag_d   = RESP_D;
        end else if (i_gnt) begin
            mem_read_d  = 1'b1;
            mem_mode_d  = MODE_WORD;
            mem_addr_d  = bus.i_addr;
            cmd_tag_d   = RESP_I;
        end
        // Memory returns data the cycle after it samples mem_read.
        resp_d = mem_read_q ? cmd_tag_q : RESP_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_mode_q  <= MODE_WORD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cmd_tag_q   <= RESP_NONE;
            resp_q      <= RESP_NONE;
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_mode_q  <= mem_mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cmd_tag_q   <= cmd_tag_d;
            resp_q      <= resp_d;
        end
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_mode  = mem_mode_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rvalid  = (resp_q == RESP_I);
    assign bus.d_rvalid  = (resp_q == RESP_D);
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; memory model returns {16'hC0DE, addr[15:0]}.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk)
        if (bus.mem_read) bus.mem_rdata <= {16'hC0DE, bus.mem_addr[15:0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_mode  = 2'd2;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    logic [31:0] b2b_data [3];

    initial begin
        b2b_data[0] = 32'hC0DE0000;
        b2b_data[1] = 32'hC0DE0004;
        b2b_data[2] = 32'hC0DE0008;
        bus.mem_rdata = '0;
        idle();

        // Reset, with both requests raised to prove grants are blocked.
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        nxt(); nxt();
        #1;
        check("rst_i_gnt", bus.i_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_mode", bus.mem_mode, 2'd2);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_i_rvalid", bus.i_rvalid, 0);
        check("rst_d_rvalid", bus.d_rvalid, 0);
        idle();
        rst = 1'b0;
        nxt();

        // Single fetch.
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        #1;
        check("f1_i_gnt", bus.i_gnt, 1);
        check("f1_d_gnt", bus.d_gnt, 0);
        nxt();
        bus.i_req = 1'b0;
        #1;
        check("f1_mem_read", bus.mem_read, 1);
        check("f1_mem_write", bus.mem_write, 0);
        check("f1_mem_addr", bus.mem_addr, 32'h10);
        check("f1_mem_mode", bus.mem_mode, 2'd2);
        check("f1_rvalid_early", bus.i_rvalid, 0);
        nxt();
        check("f1_i_rvalid", bus.i_rvalid, 1);
        check("f1_i_rdata", bus.i_rdata, 32'hC0DE0010);
        check("f1_d_rvalid", bus.d_rvalid, 0);
        nxt();
        check("f1_i_rvalid_off", bus.i_rvalid, 0);

        // Simultaneous fetch and load: data first.
        bus.i_req = 1'b1; bus.i_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        #1;
        check("sim_d_gnt", bus.d_gnt, 1);
        check("sim_i_gnt0", bus.i_gnt, 0);
        nxt();
        bus.d_req = 1'b0;
        #1;
        check("sim_i_gnt1", bus.i_gnt, 1);
        check("sim_mem_addr_d", bus.mem_addr, 32'h40);
        check("sim_mem_read_d", bus.mem_read, 1);
        nxt();
        bus.i_req = 1'b0;
        #1;
        check("sim_d_rvalid", bus.d_rvalid, 1);
        check("sim_d_rdata", bus.d_rdata, 32'hC0DE0040);
        check("sim_i_rvalid0", bus.i_rvalid, 0);
        check("sim_mem_addr_i", bus.mem_addr, 32'h20);
        nxt();
        check("sim_i_rvalid1", bus.i_rvalid, 1);
        check("sim_i_rdata", bus.i_rdata, 32'hC0DE0020);
        check("sim_d_rvalid_off", bus.d_rvalid, 0);
        nxt();

        // Byte store.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_mode = 2'd0;
        bus.d_addr = 32'h103; bus.d_wdata = 32'hAB;
        #1;
        check("st_d_gnt", bus.d_gnt, 1);
        nxt();
        idle();
        #1;
        check("st_mem_write", bus.mem_write, 1);
        check("st_mem_read", bus.mem_read, 0);
        check("st_mem_mode", bus.mem_mode, 2'd0);
        check("st_mem_addr", bus.mem_addr, 32'h103);
        check("st_mem_wdata", bus.mem_wdata, 32'hAB);
        for (int c = 0; c < 3; c++) begin
            nxt();
            check("st_no_d_rvalid", bus.d_rvalid, 0);
            check("st_mem_write_off", bus.mem_write, 0);
        end

        // Three back-to-back fetches.
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                bus.i_req = 1'b1; bus.i_addr = 32'(4 * c);
            end else begin
                bus.i_req = 1'b0;
            end
            #1;
            if (c < 3) check("b2b_i_gnt", bus.i_gnt, 1);
            if (c >= 2 && c < 5) begin
                check("b2b_i_rvalid", bus.i_rvalid, 1);
                check("b2b_i_rdata", bus.i_rdata, b2b_data[c-2]);
            end
            if (c == 5) check("b2b_i_rvalid_off", bus.i_rvalid, 0);
            nxt();
        end

        // Loads held for 10 cycles against a waiting fetch.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_mode = 2'd2; bus.d_addr = 32'h80;
        bus.i_req = 1'b1; bus.i_addr = 32'h24;
        for (int c = 0; c < 10; c++) begin
            #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
            check("stv_i_gnt", bus.i_gnt, (c == 5) ? 1 : 0);
            check("stv_d_gnt", bus.d_gnt, (c == 5) ? 0 : 1);
            nxt();
            if (c == 5) bus.i_req = 1'b0;
`else
            check("stv_i_gnt", bus.i_gnt, 0);
            check("stv_d_gnt", bus.d_gnt, 1);
            nxt();
`endif
        end
        bus.d_req = 1'b0;
        #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("stv_after_i_gnt", bus.i_gnt, 0);
`else
        check("stv_after_i_gnt", bus.i_gnt, 1);
`endif
        check("stv_after_d_gnt", bus.d_gnt, 0);
        nxt();
        idle();
        nxt(); nxt(); nxt();

        // Reset the cycle after a fetch grant: the read must vanish.
        bus.i_req = 1'b1; bus.i_addr = 32'h30;
        #1;
        check("rr_i_gnt", bus.i_gnt, 1);
        nxt();
        rst = 1'b1;
        #1;
        check("rr_gnt_in_rst", bus.i_gnt, 0);
        check("rr_mem_read_pre", bus.mem_read, 1);
        nxt();
        idle();
        #1;
        check("rr_mem_read", bus.mem_read, 0);
        check("rr_i_rvalid", bus.i_rvalid, 0);
        rst = 1'b0;
        nxt();
        check("rr_i_rvalid2", bus.i_rvalid, 0);
        check("rr_d_rvalid2", bus.d_rvalid, 0);
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h44;
        #1;
        check("rr_prio_d_gnt", bus.d_gnt, 1);
        check("rr_prio_i_gnt", bus.i_gnt, 0);
        nxt();
        idle();
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported `memory` instance between the core's instruction-fetch port and data load/store port, for unified-memory builds of rvMagic. It accepts a request from each side, grants one per cycle, and drives a registered command to the memory. It routes the one-cycle-latency read data back to the requester that issued the read. Data accesses have fixed priority over fetches. An optional starvation guard bounds fetch wait time.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports
- `DATA_WIDTH`, 32, data width on all ports
- `MODE_WIDTH`, `MEMORY_MODE_WIDTH`, width of the memory access-mode field
- `MAX_WAIT`, 4, denied cycles before a waiting fetch is forced through (≥1; used only with the guard)

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `i_req` in 1 / `i_addr` in ADDR_WIDTH: fetch request and address; held stable until `i_gnt`
- `i_gnt` out 1: fetch accepted this cycle
- `i_rvalid` out 1 / `i_rdata` out DATA_WIDTH: fetch read data valid
- `d_req` in 1 / `d_we` in 1 / `d_mode` in MODE_WIDTH / `d_addr` in ADDR_WIDTH / `d_wdata` in DATA_WIDTH: data request; held stable until `d_gnt`
- `d_gnt` out 1: data request accepted this cycle
- `d_rvalid` out 1 / `d_rdata` out DATA_WIDTH: load data valid
- `mem_read`, `mem_write` out 1 / `mem_mode` out MODE_WIDTH / `mem_addr` out ADDR_WIDTH / `mem_wdata` out DATA_WIDTH: memory command
- `mem_rdata` in DATA_WIDTH: memory read data, valid one cycle after `mem_read` is sampled

## Operation
- Arbitration is combinational from `i_req`, `d_req`, and the FSM state. At most one of `i_gnt`/`d_gnt` is high per cycle, and a grant is possible every cycle.
- FSM `ARB_D_PRIO` (reset state):
  - `d_req` wins. Otherwise `i_req` wins.
  - Transitions to `ARB_I_FORCE` when `wait_cnt == MAX_WAIT`.
- FSM `ARB_I_FORCE`:
  - `i_req` wins. Otherwise `d_req` wins.
  - Always returns to `ARB_D_PRIO` on the next edge.
- `wait_cnt`:
  - Increments, saturating at MAX_WAIT, on each cycle with `i_req && !i_gnt`.
  - Clears on `i_gnt` or when `i_req` is low.
- Command register, loaded on any grant:
  - Fetch grant: `mem_read=1`, `mem_write=0`, `mem_mode=WORD_MEMORY_MODE`, `mem_addr=i_addr`.
  - Data grant: `mem_read=!d_we`, `mem_write=d_we`, `mem_mode=d_mode`, `mem_addr=d_addr`, `mem_wdata=d_wdata`.
  - No grant: `mem_read=mem_write=0`; address, mode and wdata hold their values.
- Response tag register `resp_q ∈ {RESP_NONE, RESP_I, RESP_D}`:
  - Set from the command register whenever `mem_read` is issued; otherwise `RESP_NONE`.
  - `i_rvalid = (resp_q==RESP_I)`, `d_rvalid = (resp_q==RESP_D)`.
  - `i_rdata` and `d_rdata` pass `mem_rdata` through and are meaningful only while the matching rvalid is high.
- Writes produce no rvalid.
- Responses return in grant order, one per cycle.
- Simultaneous `i_req` and `d_req` in `ARB_D_PRIO`: data is granted and `wait_cnt` increments.
- Reset mid-operation: the command and tag registers clear, so any read in flight never produces an rvalid. `wait_cnt` returns to 0 and the FSM to `ARB_D_PRIO`.

## Timing
- Grant in cycle N means `mem_*` is driven in cycle N+1 and the matching rvalid is high in cycle N+2. Read latency is 2 cycles from grant.
- Write grant in cycle N means `mem_write` is high in cycle N+1.
- Sustained throughput is one transaction per cycle.
- `i_gnt`/`d_gnt` are 0 while `rst` is high.
- Values at and after reset:
  - `mem_read=0`, `mem_write=0`, `mem_mode=WORD_MEMORY_MODE`, `mem_addr=0`, `mem_wdata=0`.
  - `i_rvalid=0`, `d_rvalid=0`.
  - FSM=`ARB_D_PRIO`, `wait_cnt=0`, `resp_q=RESP_NONE`.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: `wait_cnt` and the `ARB_I_FORCE` state are present, as described above.
- Not defined: pure fixed data priority. `wait_cnt` and `ARB_I_FORCE` are not built, and a fetch can wait indefinitely while `d_req` stays high.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` (`ARB_D_PRIO`, `ARB_I_FORCE`).
  - `resp_tag_t` (`RESP_NONE`, `RESP_I`, `RESP_D`).
- Memory mode constants come from the existing `rv32i_defs`.
- Sub-module `mem_arb_starve_ctr` holds `wait_cnt` and the force decision, and is instantiated only under the macro.
- Everything else lives in `mem_arbiter`.

## Test plan
- Fetch only, `i_addr=0x10`: `i_gnt` high in cycle N; `mem_read=1`, `mem_addr=0x10` in N+1; `i_rvalid=1` with `i_rdata` equal to the memory word at 0x10 in N+2.
- Same-cycle `i_req` (addr 0x20) and `d_req` read (addr 0x40): `d_gnt` in N, `i_gnt` in N+1; `d_rvalid` in N+2, `i_rvalid` in N+3.
- Byte store, `d_we=1`, byte mode, `d_addr=0x103`, `d_wdata=0xAB`: `mem_write=1`, byte mode, `mem_addr=0x103` in N+1; `d_rvalid` never asserts.
- `d_req` held high for 10 cycles with `i_req` also held, MAX_WAIT=4:
  - With the macro: `i_gnt` in the 6th cycle of waiting, then `d_gnt` resumes.
  - Without the macro: no `i_gnt` until `d_req` drops.
- Three back-to-back fetches to 0x0/0x4/0x8: `i_gnt` on 3 consecutive cycles and `i_rvalid` on 3 consecutive cycles, with data in address order.
- `rst` asserted in the cycle after a read grant: `mem_read=0` next cycle, no rvalid ever for that read, FSM in `ARB_D_PRIO`.
